// File: rtl/hp_monitor_array.sv
// hp_monitor_array: multi-channel Hogge-phase supply/glitch monitor.
//
// Each channel has three parts:
//   - an f/2 toggle launcher whose data is forced low while its supply is bad
//   - an A/B phase-detector capture pair
//   - a qualifier FSM that counts fault events and latches a sticky alarm
// All channels share one phase bit and one trip threshold.
//
// Ports:
//   CK        in   rising-edge clock
//   RSTN      in   asynchronous active-low reset
//   VCC       in   [CHANNELS] supply-good per channel (0 forces launcher data to 0)
//   ARM       in   [CHANNELS] channel enable
//   glitch    in   [CHANNELS] fault injection, XORed onto the observed data
//   CLR       in   [CHANNELS] one-cycle clear of counter and sticky alarm
//   THRESH    in   [CNT_W] trip threshold, 0 disables tripping
//   AlarmRaw  out  [CHANNELS] registered qualified detector output
//   Alarm     out  [CHANNELS] sticky alarm
//   AlarmAny  out  OR of Alarm
//   FaultCnt  out  [CHANNELS*CNT_W] saturating event counters, channel c at [c*CNT_W +: CNT_W]
module hp_monitor_array #(
  parameter int unsigned          CHANNELS    = 4,
  parameter int unsigned          CNT_W       = 8,
  parameter int unsigned          WARMUP      = 4,
  parameter logic [CHANNELS-1:0]  INVERT_MASK = '0
) (
  input  logic                      CK,
  input  logic                      RSTN,
  input  logic [CHANNELS-1:0]       VCC,
  input  logic [CHANNELS-1:0]       ARM,
  input  logic [CHANNELS-1:0]       glitch,
  input  logic [CHANNELS-1:0]       CLR,
  input  logic [CNT_W-1:0]          THRESH,
  output logic [CHANNELS-1:0]       AlarmRaw,
  output logic [CHANNELS-1:0]       Alarm,
  output logic                      AlarmAny,
  output logic [CHANNELS*CNT_W-1:0] FaultCnt
);

  localparam int unsigned       WarmW    = $clog2(WARMUP + 1);
  localparam logic [WarmW-1:0]  WarmInit = WarmW'(WARMUP);
  localparam logic [CNT_W-1:0]  CntMax   = '1;

  typedef enum logic [1:0] {
    StIdle,
    StWarmup,
    StArmed,
    StTripped
  } state_e;

  // Shared launch/capture phase; each channel picks its launch polarity.
  logic ph_q;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      ph_q <= 1'b0;
    end else begin
      ph_q <= ~ph_q;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic             launch;
    logic             d;
    logic             det;
    logic             q;
    logic             evt;
    logic             data_q, data_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             raw_q, raw_d;
    logic             alarm_q, alarm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [WarmW-1:0] warm_q, warm_d;
    state_e           state_q, state_d;

    assign launch = (ph_q == INVERT_MASK[c]);
    assign d      = data_q ^ glitch[c];
    // Healthy launcher alternates, so b never matches the live data; a stuck
    // or disturbed sample makes the last three observations agree.
    assign det    = (d == b_q) && (b_q == a_q);
    assign q      = det && ((state_q == StArmed) || (state_q == StTripped));
    // Rising edge of the qualified detect: a det burst counts once.
    assign evt    = q && !raw_q;
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
      data_d = data_q;
      a_d    = a_q;
      b_d    = b_q;
      if (launch) begin
        data_d = VCC[c] ? ~data_q : 1'b0;
        b_d    = d;
      end else begin
        a_d = b_q;
        if (!VCC[c]) begin
          data_d = 1'b0;
        end
      end
    end

    always_comb begin
      state_d = state_q;
      warm_d  = warm_q;
      cnt_d   = cnt_q;
      alarm_d = alarm_q;
      raw_d   = q;
      if (CLR[c]) begin
        // Clear wins over a coincident event.
        cnt_d   = '0;
        alarm_d = 1'b0;
        raw_d   = 1'b0;
        if (ARM[c]) begin
          state_d = StWarmup;
          warm_d  = WarmInit;
        end else begin
          state_d = StIdle;
        end
      end else begin
        if (evt) begin
          cnt_d = cnt_inc;
        end
        unique case (state_q)
          StIdle: begin
            if (ARM[c]) begin
              state_d = StWarmup;
              warm_d  = WarmInit;
            end
          end
          StWarmup: begin
            if (!ARM[c]) begin
              state_d = StIdle;
            end else if (warm_q <= WarmW'(1)) begin
              state_d = StArmed;
            end else begin
              warm_d = warm_q - WarmW'(1);
            end
          end
          StArmed: begin
            // Trip takes precedence over a coincident disarm.
            if (evt && (THRESH != '0) && (cnt_inc >= THRESH)) begin
              state_d = StTripped;
              alarm_d = 1'b1;
            end else if (!ARM[c]) begin
              state_d = StIdle;
            end
          end
          StTripped: begin
            alarm_d = 1'b1;
          end
          default: begin
            state_d = StIdle;
          end
        endcase
      end
    end

    always_ff @(posedge CK or negedge RSTN) begin
      if (!RSTN) begin
        data_q  <= 1'b0;
        a_q     <= 1'b0;
        b_q     <= 1'b0;
        raw_q   <= 1'b0;
        alarm_q <= 1'b0;
        cnt_q   <= '0;
        warm_q  <= '0;
        state_q <= StIdle;
      end else begin
        data_q  <= data_d;
        a_q     <= a_d;
        b_q     <= b_d;
        raw_q   <= raw_d;
        alarm_q <= alarm_d;
        cnt_q   <= cnt_d;
        warm_q  <= warm_d;
        state_q <= state_d;
      end
    end

    assign AlarmRaw[c]                  = raw_q;
    assign Alarm[c]                     = alarm_q;
    assign FaultCnt[c*CNT_W +: CNT_W]   = cnt_q;
  end

  assign AlarmAny = |Alarm;

endmodule
